// File: rtl/apb_master_arb.sv
// Two-requester APB arbiter: round-robin grant, re-timed downstream transfer,
// response returned only to the winner, watchdog on hung ACCESS phases.
module apb_master_arb #(
  parameter int unsigned APB_ADDR_WIDTH = 32,
  parameter int unsigned APB_DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                      clk,
  input  logic                      rst_n,

  input  logic [APB_ADDR_WIDTH-1:0] m0_paddr,
  input  logic [APB_DATA_WIDTH-1:0] m0_pwdata,
  input  logic                      m0_pwrite,
  input  logic                      m0_psel,
  input  logic                      m0_penable,
  output logic [APB_DATA_WIDTH-1:0] m0_prdata,
  output logic                      m0_pready,
  output logic                      m0_pslverr,

  input  logic [APB_ADDR_WIDTH-1:0] m1_paddr,
  input  logic [APB_DATA_WIDTH-1:0] m1_pwdata,
  input  logic                      m1_pwrite,
  input  logic                      m1_psel,
  input  logic                      m1_penable,
  output logic [APB_DATA_WIDTH-1:0] m1_prdata,
  output logic                      m1_pready,
  output logic                      m1_pslverr,

  output logic [APB_ADDR_WIDTH-1:0] out_paddr,
  output logic [APB_DATA_WIDTH-1:0] out_pwdata,
  output logic                      out_pwrite,
  output logic                      out_psel,
  output logic                      out_penable,
  input  logic [APB_DATA_WIDTH-1:0] out_prdata,
  input  logic                      out_pready,
  input  logic                      out_pslverr,

  output logic                      grant_o,
  output logic                      timeout_o
);

  // Counter keeps at least one bit so a disabled watchdog still elaborates.
  localparam int unsigned CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t                    state_q, state_d;
  logic                      grant_q, last_grant_q;
  logic [APB_ADDR_WIDTH-1:0] addr_q;
  logic [APB_DATA_WIDTH-1:0] wdata_q;
  logic                      write_q;
  logic [APB_DATA_WIDTH-1:0] rdata_q;
  logic                      slverr_q;
  logic [CW-1:0]             cnt_q;

  logic win_en, win_sel, cap_resp, timeout_hit;

  // Requester penable carries no information the arbiter needs: psel alone marks a pending request.
  logic unused_penable;
  assign unused_penable = m0_penable ^ m1_penable;

  always_comb begin
    state_d     = state_q;
    win_en      = 1'b0;
    win_sel     = 1'b0;
    cap_resp    = 1'b0;
    timeout_hit = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (m0_psel && m1_psel) begin
          win_en  = 1'b1;
          win_sel = ~last_grant_q;
        end else if (m0_psel) begin
          win_en  = 1'b1;
          win_sel = 1'b0;
        end else if (m1_psel) begin
          win_en  = 1'b1;
          win_sel = 1'b1;
        end
        if (win_en) state_d = SETUP;
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        if (out_pready) begin
          cap_resp = 1'b1;
          state_d  = RESP;
        end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CW'(TIMEOUT_CYCLES))) begin
          timeout_hit = 1'b1;
          state_d     = RESP;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      addr_q       <= '0;
      wdata_q      <= '0;
      write_q      <= 1'b0;
      rdata_q      <= '0;
      slverr_q     <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q <= state_d;
      if (win_en) begin
        addr_q       <= win_sel ? m1_paddr  : m0_paddr;
        wdata_q      <= win_sel ? m1_pwdata : m0_pwdata;
        write_q      <= win_sel ? m1_pwrite : m0_pwrite;
        grant_q      <= win_sel;
        last_grant_q <= win_sel;
      end
      if (cap_resp) begin
        rdata_q  <= out_prdata;
        slverr_q <= out_pslverr;
      end else if (timeout_hit) begin
        rdata_q  <= '0;
        slverr_q <= 1'b1;
      end
      // Cleared on the way into SETUP; saturates rather than wrapping.
      if (win_en) begin
        cnt_q <= '0;
      end else if ((state_q == ACCESS) && (cnt_q != '1)) begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  // Bus strobes decode straight from the state register so reset drops them asynchronously.
  assign out_psel    = (state_q == SETUP) || (state_q == ACCESS);
  assign out_penable = (state_q == ACCESS);
  assign out_paddr   = addr_q;
  assign out_pwdata  = wdata_q;
  assign out_pwrite  = write_q;

  assign grant_o   = grant_q;
  assign timeout_o = timeout_hit;

  // A winner that dropped psel before RESP simply never sees its response.
  assign m0_pready  = (state_q == RESP) && !grant_q && m0_psel;
  assign m1_pready  = (state_q == RESP) &&  grant_q && m1_psel;
  assign m0_prdata  = m0_pready ? rdata_q : '0;
  assign m1_prdata  = m1_pready ? rdata_q : '0;
  assign m0_pslverr = m0_pready & slverr_q;
  assign m1_pslverr = m1_pready & slverr_q;

endmodule

// File: tb/tb_apb_master_arb.sv
// Directed bench for apb_master_arb: one instance with an 8-cycle watchdog, one with it disabled.
module tb_apb_master_arb;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic          clk, rst_n;
  logic [AW-1:0] m0_paddr, m1_paddr;
  logic [DW-1:0] m0_pwdata, m1_pwdata;
  logic          m0_pwrite, m0_psel, m0_penable;
  logic          m1_pwrite, m1_psel, m1_penable;
  logic [DW-1:0] out_prdata;
  logic          out_pready, out_pslverr;

  logic [DW-1:0] m0_prdata, m1_prdata;
  logic          m0_pready, m0_pslverr, m1_pready, m1_pslverr;
  logic [AW-1:0] out_paddr;
  logic [DW-1:0] out_pwdata;
  logic          out_pwrite, out_psel, out_penable, grant_o, timeout_o;

  logic [DW-1:0] nt_m0_prdata, nt_m1_prdata;
  logic          nt_m0_pready, nt_m0_pslverr, nt_m1_pready, nt_m1_pslverr;
  logic [AW-1:0] nt_out_paddr;
  logic [DW-1:0] nt_out_pwdata;
  logic          nt_out_pwrite, nt_out_psel, nt_out_penable, nt_grant_o, nt_timeout_o;

  int n_cmp = 0;
  int n_err = 0;

  apb_master_arb #(.APB_ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_paddr(m0_paddr), .m0_pwdata(m0_pwdata), .m0_pwrite(m0_pwrite), .m0_psel(m0_psel),
    .m0_penable(m0_penable), .m0_prdata(m0_prdata), .m0_pready(m0_pready), .m0_pslverr(m0_pslverr),
    .m1_paddr(m1_paddr), .m1_pwdata(m1_pwdata), .m1_pwrite(m1_pwrite), .m1_psel(m1_psel),
    .m1_penable(m1_penable), .m1_prdata(m1_prdata), .m1_pready(m1_pready), .m1_pslverr(m1_pslverr),
    .out_paddr(out_paddr), .out_pwdata(out_pwdata), .out_pwrite(out_pwrite), .out_psel(out_psel),
    .out_penable(out_penable), .out_prdata(out_prdata), .out_pready(out_pready), .out_pslverr(out_pslverr),
    .grant_o(grant_o), .timeout_o(timeout_o)
  );

  apb_master_arb #(.APB_ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW), .TIMEOUT_CYCLES(0)) dut_nt (
    .clk(clk), .rst_n(rst_n),
    .m0_paddr(m0_paddr), .m0_pwdata(m0_pwdata), .m0_pwrite(m0_pwrite), .m0_psel(m0_psel),
    .m0_penable(m0_penable), .m0_prdata(nt_m0_prdata), .m0_pready(nt_m0_pready), .m0_pslverr(nt_m0_pslverr),
    .m1_paddr(m1_paddr), .m1_pwdata(m1_pwdata), .m1_pwrite(m1_pwrite), .m1_psel(m1_psel),
    .m1_penable(m1_penable), .m1_prdata(nt_m1_prdata), .m1_pready(nt_m1_pready), .m1_pslverr(nt_m1_pslverr),
    .out_paddr(nt_out_paddr), .out_pwdata(nt_out_pwdata), .out_pwrite(nt_out_pwrite), .out_psel(nt_out_psel),
    .out_penable(nt_out_penable), .out_prdata(out_prdata), .out_pready(out_pready), .out_pslverr(out_pslverr),
    .grant_o(nt_grant_o), .timeout_o(nt_timeout_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    m0_paddr = '0; m0_pwdata = '0; m0_pwrite = 1'b0; m0_psel = 1'b0; m0_penable = 1'b0;
    m1_paddr = '0; m1_pwdata = '0; m1_pwrite = 1'b0; m1_psel = 1'b0; m1_penable = 1'b0;
    out_prdata = '0; out_pready = 1'b0; out_pslverr = 1'b0;
  endtask

  // Leaves the bench #1 after a rising edge with both DUTs in IDLE (cycle 0).
  task automatic do_reset;
    rst_n = 1'b0;
    clear_inputs();
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    clear_inputs();
    #3;
    n_cmp++; if ({out_psel, out_penable, out_pwrite, m0_pready, m0_pslverr, m1_pready, m1_pslverr, grant_o, timeout_o} !== 9'b0) begin
      n_err++; $display("FAIL reset_ctrl: got %b want 000000000", {out_psel, out_penable, out_pwrite, m0_pready, m0_pslverr, m1_pready, m1_pslverr, grant_o, timeout_o}); end
    n_cmp++; if ({out_paddr, out_pwdata, m0_prdata, m1_prdata} !== 128'b0) begin
      n_err++; $display("FAIL reset_data: got %h want 0", {out_paddr, out_pwdata, m0_prdata, m1_prdata}); end
    n_cmp++; if ({nt_out_psel, nt_out_penable, nt_out_pwrite, nt_m0_pready, nt_m0_pslverr, nt_m1_pready, nt_m1_pslverr, nt_grant_o, nt_timeout_o} !== 9'b0) begin
      n_err++; $display("FAIL reset_nt_ctrl: got %b want 000000000", {nt_out_psel, nt_out_penable, nt_out_pwrite, nt_m0_pready, nt_m0_pslverr, nt_m1_pready, nt_m1_pslverr, nt_grant_o, nt_timeout_o}); end
    n_cmp++; if ({nt_out_paddr, nt_out_pwdata, nt_m0_prdata, nt_m1_prdata} !== 128'b0) begin
      n_err++; $display("FAIL reset_nt_data: got %h want 0", {nt_out_paddr, nt_out_pwdata, nt_m0_prdata, nt_m1_prdata}); end
  endtask

  task automatic test_single_write;
    do_reset();
    m0_paddr = 32'h1A10_1000; m0_pwdata = 32'hDEAD_BEEF; m0_pwrite = 1'b1; m0_psel = 1'b1;
    out_pready = 1'b1;
    #1;
    n_cmp++; if (out_psel !== 1'b0) begin n_err++; $display("FAIL sw_c0_psel: got %b want 0", out_psel); end
    next_cycle();  // cycle 1
    m0_penable = 1'b1;
    n_cmp++; if ({out_psel, out_penable} !== 2'b10) begin n_err++; $display("FAIL sw_c1_strobes: got %b want 10", {out_psel, out_penable}); end
    n_cmp++; if (out_paddr !== 32'h1A10_1000) begin n_err++; $display("FAIL sw_c1_addr: got %h want 1a101000", out_paddr); end
    n_cmp++; if (out_pwdata !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL sw_c1_wdata: got %h want deadbeef", out_pwdata); end
    n_cmp++; if ({out_pwrite, grant_o} !== 2'b10) begin n_err++; $display("FAIL sw_c1_write_grant: got %b want 10", {out_pwrite, grant_o}); end
    m0_paddr = 32'h0000_0BAD; m0_pwdata = 32'h0;
    next_cycle();  // cycle 2
    n_cmp++; if ({out_psel, out_penable} !== 2'b11) begin n_err++; $display("FAIL sw_c2_strobes: got %b want 11", {out_psel, out_penable}); end
    n_cmp++; if ({out_paddr, out_pwdata} !== {32'h1A10_1000, 32'hDEAD_BEEF}) begin
      n_err++; $display("FAIL sw_c2_held: got %h want 1a101000deadbeef", {out_paddr, out_pwdata}); end
    next_cycle();  // cycle 3
    n_cmp++; if ({m0_pready, m0_pslverr, m1_pready} !== 3'b100) begin n_err++; $display("FAIL sw_c3_ready: got %b want 100", {m0_pready, m0_pslverr, m1_pready}); end
    n_cmp++; if ({out_psel, out_penable} !== 2'b00) begin n_err++; $display("FAIL sw_c3_strobes: got %b want 00", {out_psel, out_penable}); end
    next_cycle();  // cycle 4
    m0_psel = 1'b0; m0_penable = 1'b0; out_pready = 1'b0;
    n_cmp++; if (m0_pready !== 1'b0) begin n_err++; $display("FAIL sw_c4_ready: got %b want 0", m0_pready); end
  endtask

  task automatic test_round_robin;
    logic          w;
    logic [DW-1:0] exp0, exp1;
    do_reset();
    m0_paddr = 32'h1000_0000; m1_paddr = 32'h2000_0000;
    m0_pwrite = 1'b0; m1_pwrite = 1'b0; m0_psel = 1'b1; m1_psel = 1'b1;
    out_pready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      w = i[0];
      exp0 = w ? 32'h0 : 32'h1111_1111;
      exp1 = w ? 32'h2222_2222 : 32'h0;
      out_prdata = w ? 32'h2222_2222 : 32'h1111_1111;
      next_cycle();  // SETUP
      n_cmp++; if (grant_o !== w) begin n_err++; $display("FAIL rr%0d_grant: got %b want %b", i, grant_o, w); end
      n_cmp++; if (out_paddr !== (w ? 32'h2000_0000 : 32'h1000_0000)) begin
        n_err++; $display("FAIL rr%0d_addr: got %h want %h", i, out_paddr, (w ? 32'h2000_0000 : 32'h1000_0000)); end
      next_cycle();  // ACCESS
      next_cycle();  // RESP
      n_cmp++; if ({m0_pready, m1_pready} !== {~w, w}) begin n_err++; $display("FAIL rr%0d_ready: got %b want %b", i, {m0_pready, m1_pready}, {~w, w}); end
      n_cmp++; if ({m0_prdata, m1_prdata} !== {exp0, exp1}) begin
        n_err++; $display("FAIL rr%0d_rdata: got %h want %h", i, {m0_prdata, m1_prdata}, {exp0, exp1}); end
      next_cycle();  // IDLE between transfers
      n_cmp++; if (out_psel !== 1'b0) begin n_err++; $display("FAIL rr%0d_gap: got psel %b want 0", i, out_psel); end
    end
    m0_psel = 1'b0; m1_psel = 1'b0; out_pready = 1'b0;
  endtask

  task automatic test_wait_states;
    do_reset();
    m1_paddr = 32'h3000_0040; m1_pwrite = 1'b0; m1_psel = 1'b1;
    out_prdata = 32'hCAFE_0001;
    next_cycle();  // cycle 1
    next_cycle();  // cycle 2
    m0_paddr = 32'h1000_0004; m0_pwdata = 32'h55; m0_pwrite = 1'b1; m0_psel = 1'b1;
    n_cmp++; if ({out_penable, grant_o} !== 2'b11) begin n_err++; $display("FAIL ws_c2_access: got %b want 11", {out_penable, grant_o}); end
    next_cycle();  // cycle 3
    next_cycle();  // cycle 4
    n_cmp++; if (m1_pready !== 1'b0) begin n_err++; $display("FAIL ws_c4_ready: got %b want 0", m1_pready); end
    next_cycle();  // cycle 5
    out_pready = 1'b1; out_pslverr = 1'b1;
    n_cmp++; if (out_penable !== 1'b1) begin n_err++; $display("FAIL ws_c5_penable: got %b want 1", out_penable); end
    next_cycle();  // cycle 6
    out_pready = 1'b0; out_pslverr = 1'b0;
    n_cmp++; if ({m1_pready, m1_pslverr, m0_pready} !== 3'b110) begin n_err++; $display("FAIL ws_c6_resp: got %b want 110", {m1_pready, m1_pslverr, m0_pready}); end
    n_cmp++; if (m1_prdata !== 32'hCAFE_0001) begin n_err++; $display("FAIL ws_c6_rdata: got %h want cafe0001", m1_prdata); end
    next_cycle();  // cycle 7
    m1_psel = 1'b0;
    n_cmp++; if (out_psel !== 1'b0) begin n_err++; $display("FAIL ws_c7_idle: got psel %b want 0", out_psel); end
    next_cycle();  // cycle 8
    out_pready = 1'b1;
    n_cmp++; if ({out_psel, grant_o, out_pwrite} !== 3'b101) begin n_err++; $display("FAIL ws_c8_m0_setup: got %b want 101", {out_psel, grant_o, out_pwrite}); end
    n_cmp++; if (out_paddr !== 32'h1000_0004) begin n_err++; $display("FAIL ws_c8_addr: got %h want 10000004", out_paddr); end
    next_cycle();  // cycle 9
    next_cycle();  // cycle 10
    n_cmp++; if ({m0_pready, m0_pslverr} !== 2'b10) begin n_err++; $display("FAIL ws_c10_m0_resp: got %b want 10", {m0_pready, m0_pslverr}); end
    next_cycle();
    m0_psel = 1'b0; out_pready = 1'b0;
  endtask

  task automatic test_timeout;
    int pulses;
    pulses = 0;
    do_reset();
    m0_paddr = 32'h4000_0000; m0_pwdata = 32'h77; m0_pwrite = 1'b1; m0_psel = 1'b1;
    out_prdata = 32'hFFFF_FFFF;
    for (int c = 1; c <= 10; c++) begin
      next_cycle();
      pulses += int'(timeout_o);
      n_cmp++; if (timeout_o !== (c == 10)) begin n_err++; $display("FAIL to_c%0d_pulse: got %b want %b", c, timeout_o, (c == 10)); end
    end
    next_cycle();  // cycle 11
    pulses += int'(timeout_o);
    n_cmp++; if ({m0_pready, m0_pslverr} !== 2'b11) begin n_err++; $display("FAIL to_resp: got %b want 11", {m0_pready, m0_pslverr}); end
    n_cmp++; if (m0_prdata !== 32'h0) begin n_err++; $display("FAIL to_rdata: got %h want 0", m0_prdata); end
    n_cmp++; if (pulses != 1) begin n_err++; $display("FAIL to_pulse_count: got %0d want 1", pulses); end
    next_cycle();  // cycle 12: IDLE, issue a normal read
    m0_paddr = 32'h4000_0008; m0_pwrite = 1'b0;
    out_pready = 1'b1; out_prdata = 32'h1234_5678;
    n_cmp++; if (m0_pready !== 1'b0) begin n_err++; $display("FAIL to_c12_ready: got %b want 0", m0_pready); end
    next_cycle();
    next_cycle();
    next_cycle();  // cycle 15
    n_cmp++; if ({m0_pready, m0_pslverr, timeout_o} !== 3'b100) begin n_err++; $display("FAIL to_next_resp: got %b want 100", {m0_pready, m0_pslverr, timeout_o}); end
    n_cmp++; if (m0_prdata !== 32'h1234_5678) begin n_err++; $display("FAIL to_next_rdata: got %h want 12345678", m0_prdata); end
    next_cycle();
    m0_psel = 1'b0; out_pready = 1'b0;
  endtask

  task automatic test_reset_mid;
    do_reset();
    m1_paddr = 32'h5000_0000; m1_pwrite = 1'b1; m1_psel = 1'b1;
    next_cycle();
    next_cycle();  // cycle 2: ACCESS
    n_cmp++; if ({out_penable, grant_o} !== 2'b11) begin n_err++; $display("FAIL rm_access: got %b want 11", {out_penable, grant_o}); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if ({out_psel, out_penable, out_pwrite, grant_o} !== 4'b0) begin n_err++; $display("FAIL rm_async: got %b want 0000", {out_psel, out_penable, out_pwrite, grant_o}); end
    n_cmp++; if (out_paddr !== 32'h0) begin n_err++; $display("FAIL rm_addr: got %h want 0", out_paddr); end
    m1_psel = 1'b0;
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
    m0_paddr = 32'h6000_0000; m1_paddr = 32'h7000_0000; m0_psel = 1'b1; m1_psel = 1'b1;
    next_cycle();
    n_cmp++; if ({out_psel, grant_o} !== 2'b10) begin n_err++; $display("FAIL rm_tie_grant: got %b want 10", {out_psel, grant_o}); end
    n_cmp++; if (out_paddr !== 32'h6000_0000) begin n_err++; $display("FAIL rm_tie_addr: got %h want 60000000", out_paddr); end
    m0_psel = 1'b0; m1_psel = 1'b0;
  endtask

  task automatic test_psel_drop;
    do_reset();
    m0_paddr = 32'h0000_0100; m0_psel = 1'b1;
    out_pready = 1'b1; out_prdata = 32'h0000_ABCD;
    next_cycle();
    next_cycle();  // cycle 2
    m0_psel = 1'b0;
    next_cycle();  // cycle 3: RESP with psel gone
    n_cmp++; if ({m0_pready, m1_pready} !== 2'b00) begin n_err++; $display("FAIL pd_ready: got %b want 00", {m0_pready, m1_pready}); end
    n_cmp++; if (m0_prdata !== 32'h0) begin n_err++; $display("FAIL pd_rdata: got %h want 0", m0_prdata); end
    next_cycle();  // cycle 4
    n_cmp++; if (out_psel !== 1'b0) begin n_err++; $display("FAIL pd_idle: got psel %b want 0", out_psel); end
    out_pready = 1'b0;
  endtask

  task automatic test_no_timeout;
    logic fired, early;
    fired = 1'b0; early = 1'b0;
    do_reset();
    m1_paddr = 32'h8000_0000; m1_pwrite = 1'b0; m1_psel = 1'b1;
    out_prdata = 32'h0BAD_F00D;
    next_cycle();  // cycle 1
    for (int i = 0; i < 300; i++) begin
      next_cycle();  // cycles 2..301
      fired = fired | nt_timeout_o;
      early = early | nt_m1_pready;
    end
    next_cycle();  // cycle 302
    out_pready = 1'b1;
    fired = fired | nt_timeout_o;
    n_cmp++; if (nt_out_penable !== 1'b1) begin n_err++; $display("FAIL nt_still_access: got %b want 1", nt_out_penable); end
    next_cycle();  // cycle 303
    n_cmp++; if ({fired, early} !== 2'b00) begin n_err++; $display("FAIL nt_no_fire: got %b want 00", {fired, early}); end
    n_cmp++; if ({nt_m1_pready, nt_m1_pslverr} !== 2'b10) begin n_err++; $display("FAIL nt_resp: got %b want 10", {nt_m1_pready, nt_m1_pslverr}); end
    n_cmp++; if (nt_m1_prdata !== 32'h0BAD_F00D) begin n_err++; $display("FAIL nt_rdata: got %h want 0badf00d", nt_m1_prdata); end
    next_cycle();
    m1_psel = 1'b0; out_pready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_round_robin();
    test_wait_states();
    test_timeout();
    test_reset_mid();
    test_psel_drop();
    test_no_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL sim_time_limit: got no completion want completion before 50000");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/apb_master_arb.md
# apb_master_arb

Two-master APB arbiter that shares the single peripheral APB bus (feeding the peripheral address decoder) between the core-data bridge (requester 0) and the debug/JTAG APB master (requester 1). It arbitrates round-robin, re-times the winning transfer onto the downstream bus, and returns the response only to the winner. The loser is held in APB wait states. A watchdog terminates any downstream access that hangs.

## Interface
- APB_ADDR_WIDTH, 32, address width of all three ports
- APB_DATA_WIDTH, 32, data width of all three ports
- TIMEOUT_CYCLES, 255, maximum ACCESS cycles before forced error; 0 disables the watchdog
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- mX_paddr, mX_pwdata, mX_pwrite, mX_psel, mX_penable  in  ADDR/DATA/1/1/1  requester X (X=0,1) APB request
- mX_prdata, mX_pready, mX_pslverr  out  DATA/1/1  requester X APB response
- out_paddr, out_pwdata, out_pwrite, out_psel, out_penable  out  ADDR/DATA/1/1/1  downstream APB request
- out_prdata, out_pready, out_pslverr  in  DATA/1/1  downstream APB response
- grant_o  out  1  index of the current or last winner
- timeout_o  out  1  one-cycle pulse when the watchdog fires

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP. Reset state is IDLE.
- IDLE: a requester is pending when mX_psel=1.
  - One pending: it wins.
  - Both pending: the one not equal to last_grant wins. last_grant resets to 1, so m0 wins the first tie.
  - On a win: capture winner paddr/pwdata/pwrite into registers, set grant_o, set last_grant, go to SETUP.
- SETUP: out_psel=1, out_penable=0. Always go to ACCESS next cycle.
- ACCESS: out_psel=1, out_penable=1. Watchdog counter increments each cycle.
  - If out_pready=1: capture out_prdata/out_pslverr, go to RESP.
  - Else if TIMEOUT_CYCLES≠0 and counter reaches TIMEOUT_CYCLES: capture prdata=0, pslverr=1, pulse timeout_o, go to RESP.
- RESP: out_psel=out_penable=0.
  - m[grant]_pready=1 with the captured prdata/pslverr for exactly one cycle, then go to IDLE.
  - If the winner has dropped mX_psel by RESP (protocol violation): the response is discarded and the FSM still returns to IDLE.
- mX_pready is 0 for the non-winner at all times. mX_prdata and mX_pslverr are 0 whenever mX_pready=0.
- Downstream request outputs come only from the captured registers. A requester changing address or data mid-transfer does not affect the bus.
- Watchdog counter width is $clog2(TIMEOUT_CYCLES+1). It clears on entry to SETUP and never wraps.

## Timing
- Reset values: all out_* and mX_* outputs 0; grant_o=0; timeout_o=0; last_grant=1; FSM IDLE; counter 0.
- Reset asserted mid-transfer: immediate return to reset values. Downstream psel and penable drop asynchronously.
- Uncontended latency, with the requester raising psel at cycle 0:
  - out_psel at cycle 1, out_penable at cycle 2.
  - If out_pready=1 at cycle 2, mX_pready=1 at cycle 3. Minimum 4 cycles per transfer including the return to IDLE.
- Each downstream wait state adds one cycle of requester latency.
- Back-to-back: the earliest next SETUP is 2 cycles after RESP (RESP→IDLE→SETUP).
- A requester arriving during an active transfer waits until the FSM returns to IDLE. No preemption.
- Simultaneous request arrival and completion: arbitration is evaluated only in IDLE, using last_grant already updated by the finished transfer.
- Timeout: with the downstream never ready, timeout_o pulses in the ACCESS cycle where the counter equals TIMEOUT_CYCLES. mX_pready/pslverr=1 follow one cycle later.

## Test plan
- Single m0 write, paddr=0x1A10_1000, pwdata=0xDEADBEEF, downstream ready at once:
  - out_psel at cycle 1, out_penable at cycle 2 with the same addr/data/pwrite=1.
  - m0_pready=1 at cycle 3; m1_pready stays 0.
- m0 and m1 reads issued in the same cycle, repeated 4 times:
  - Grants alternate m0,m1,m0,m1,…
  - Each requester receives only its own prdata (0x1111_1111 / 0x2222_2222).
  - grant_o tracks the winner.
- m1 read with downstream inserting 3 wait states, pslverr=1:
  - m1_pready at cycle 6 with pslverr=1 and the captured prdata.
  - m0 requesting at cycle 2 is served only after IDLE.
- TIMEOUT_CYCLES=8, downstream pready held at 0:
  - timeout_o pulses once; requester gets pready=1, pslverr=1, prdata=0.
  - FSM returns to IDLE and the next transfer completes normally.
- rst_n pulsed low during ACCESS:
  - All outputs go to 0 immediately.
  - After release, a simultaneous request grants m0 first.
- TIMEOUT_CYCLES=0 with 300 downstream wait states: no timeout. The transfer completes when pready rises.
